// File: rtl/ram_alu_datapath_if.sv
// Memory/ALU bus bundle between the CPU sequencer and the datapath slice.
// The tri-state data bus stays a plain inout on the datapath.
interface ram_alu_datapath_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] addr;
  logic                  cs_input;
  logic                  we;
  logic                  oe;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [3:0]            aluMode;
  logic [DATA_WIDTH-1:0] s;
  logic [3:0]            flags;

  modport master (
    output addr, cs_input, we, oe,
    output a, b, aluMode,
    input  s, flags
  );

  modport slave (
    input  addr, cs_input, we, oe,
    input  a, b, aluMode,
    output s, flags
  );
endinterface

// File: rtl/ram_alu_datapath.sv
// 256x8 synchronous RAM with tri-state bus plus an 8-bit ALU.
// Memory is not reset; only the read register is.
module ram_alu_datapath #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  inout  wire  [DATA_WIDTH-1:0] data,
  ram_alu_datapath_if.slave     bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int M     = DATA_WIDTH - 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd;

  logic                  w_wr;
  logic                  w_rd;
  logic                  w_drive;
  logic [DATA_WIDTH-1:0] w_a;
  logic [DATA_WIDTH-1:0] w_b;
  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH-1:0] w_s;
  logic                  w_c;
  logic                  w_v;

  assign w_wr    = bus.cs_input & bus.we;
  assign w_rd    = bus.cs_input & ~bus.we;
  assign w_drive = w_rd & bus.oe & ~rst;

  assign data = w_drive ? r_rd : {DATA_WIDTH{1'bz}};

  // Storage write; contents survive reset, writes blocked during reset
  always_ff @(posedge clk) begin
    if (!rst && w_wr)
      r_mem[bus.addr] <= data;
  end

  // Read register: loads only on read cycles, holds otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_rd <= '0;
    else if (w_rd)
      r_rd <= r_mem[bus.addr];
  end

  assign w_a = bus.a;
  assign w_b = bus.b;

  // ALU result and carry/overflow; subtract carry is NOT borrow
  always_comb begin
    w_sum = '0;
    w_s   = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    unique case (bus.aluMode)
      4'h0: w_s = w_a;
      4'h1: begin
        w_sum = {1'b0, w_a} + {1'b0, w_b};
        w_s   = w_sum[M:0];
        w_c   = w_sum[DATA_WIDTH];
        w_v   = (w_a[M] == w_b[M]) && (w_s[M] != w_a[M]);
      end
      4'h2: begin
        w_sum = {1'b0, w_a} + {1'b0, ~w_b}
              + {{DATA_WIDTH{1'b0}}, 1'b1};
        w_s   = w_sum[M:0];
        w_c   = w_sum[DATA_WIDTH];
        w_v   = (w_a[M] != w_b[M]) && (w_s[M] != w_a[M]);
      end
      4'h3: w_s = w_a & w_b;
      4'h4: w_s = w_a | w_b;
      4'h5: w_s = w_a ^ w_b;
      4'h6: w_s = ~w_a;
      4'h7: begin
        w_s = {w_a[M-1:0], 1'b0};
        w_c = w_a[M];
      end
      4'h8: begin
        w_s = {1'b0, w_a[M:1]};
        w_c = w_a[0];
      end
      4'h9: begin
        w_s = {w_a[M], w_a[M:1]};
        w_c = w_a[0];
      end
      4'hA: begin
        w_s = {w_a[M-1:0], w_a[M]};
        w_c = w_a[M];
      end
      4'hB: begin
        w_s = {w_a[0], w_a[M:1]};
        w_c = w_a[0];
      end
      4'hC: begin
        w_sum = {1'b0, w_a} + {{DATA_WIDTH{1'b0}}, 1'b1};
        w_s   = w_sum[M:0];
        w_c   = w_sum[DATA_WIDTH];
        w_v   = ~w_a[M] & w_s[M];
      end
      4'hD: begin
        w_sum = {1'b0, w_a} + {1'b0, {DATA_WIDTH{1'b1}}};
        w_s   = w_sum[M:0];
        w_c   = w_sum[DATA_WIDTH];
        w_v   = w_a[M] & ~w_s[M];
      end
      4'hE: w_s = '0;
      4'hF: w_s = w_b;
    endcase
  end

  assign bus.s     = w_s;
  assign bus.flags = {w_s[M], ~|w_s, w_c, w_v};
endmodule

// File: tb/tb_ram_alu_datapath.sv
// Bench for ram_alu_datapath: directed bus/ALU cases plus
// random traffic against an array memory and arithmetic ALU model.
module tb_ram_alu_datapath;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic       tb_en  = 1'b0;
  logic [7:0] tb_drv = 8'h00;
  wire  [7:0] data;

  int n_err = 0;
  int n_chk = 0;
  int mdl [256];
  bit vld [256];
  int last = 0;

  ram_alu_datapath_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

  ram_alu_datapath #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .data (data),
    .bus  (bus)
  );

  assign data = tb_en ? tb_drv : 8'bzzzzzzzz;

  // Undriven bus reads back as 0xFF
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (data[i]);
  end

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  function automatic int ovf(input int r);
    return (r > 127 || r < -128) ? 1 : 0;
  endfunction

  task automatic alu_ref(input int m, input int a, input int b,
                         output int s, output int f);
    int r, c, v;
    r = 0; c = 0; v = 0;
    case (m)
      0:  r = a;
      1:  begin r = a + b; c = (r > 255); v = ovf(sx(a) + sx(b)); end
      2:  begin r = a - b; c = (a >= b); v = ovf(sx(a) - sx(b)); end
      3:  r = a & b;
      4:  r = a | b;
      5:  r = a ^ b;
      6:  r = 255 - a;
      7:  begin r = a * 2; c = a / 128; end
      8:  begin r = a / 2; c = a % 2; end
      9:  begin r = a / 2 + ((a >= 128) ? 128 : 0); c = a % 2; end
      10: begin r = (a * 2) % 256 + a / 128; c = a / 128; end
      11: begin r = a / 2 + (a % 2) * 128; c = a % 2; end
      12: begin r = a + 1; c = (r > 255); v = ovf(sx(a) + 1); end
      13: begin r = a - 1; c = (a >= 1); v = ovf(sx(a) - 1); end
      14: r = 0;
      default: r = b;
    endcase
    s = ((r % 256) + 256) % 256;
    f = ((s >= 128) ? 8 : 0) + ((s == 0) ? 4 : 0) + c * 2 + v;
  endtask

  function automatic logic [31:0] bus32();
    return {24'h0, data};
  endfunction

  task automatic wr(input int ad, input int v);
    bus.cs_input = 1'b1;
    bus.we       = 1'b1;
    bus.oe       = 1'b1;
    bus.addr     = 8'(ad);
    tb_drv       = 8'(v);
    tb_en        = 1'b1;
    #1;
    chk("wr_bus", bus32(), 32'(v));
    @(posedge clk); #1;
    mdl[ad] = v;
    vld[ad] = 1'b1;
    tb_en   = 1'b0;
    bus.we  = 1'b0;
    #1;
    chk("rdw_hold", bus32(), 32'(last));
  endtask

  task automatic rd(input int ad);
    bus.cs_input = 1'b1;
    bus.we       = 1'b0;
    bus.oe       = 1'b1;
    bus.addr     = 8'(ad);
    #1;
    chk("rd_pre", bus32(), 32'(last));
    @(posedge clk); #1;
    last = mdl[ad];
    chk("rd", bus32(), 32'(last));
  endtask

  task automatic alu_chk(input string tag, input int m,
                         input int a, input int b,
                         input int es, input int ef);
    bus.aluMode = 4'(m);
    bus.a       = 8'(a);
    bus.b       = 8'(b);
    #1;
    chk({tag, "_s"}, {24'h0, bus.s}, 32'(es));
    chk({tag, "_f"}, {28'h0, bus.flags}, 32'(ef));
  endtask

  initial begin
    int s, f, a, b, m, ad;
    bus.addr     = '0;
    bus.cs_input = 1'b1;
    bus.we       = 1'b0;
    bus.oe       = 1'b1;
    bus.a        = '0;
    bus.b        = '0;
    bus.aluMode  = '0;
    for (int i = 0; i < 256; i++) begin
      mdl[i] = 0;
      vld[i] = 1'b0;
    end

    // reset: bus floats, read register cleared
    repeat (2) @(posedge clk);
    #1;
    chk("rst_z", bus32(), 32'hFF);
    rst = 1'b0;
    #1;
    last = 0;
    chk("rst_rdreg", bus32(), 32'h00);

    // basic write/read with one-edge latency
    wr(8'h00, 8'h10);
    wr(8'h01, 8'h0C);
    rd(8'h00);
    rd(8'h01);

    // bus control
    bus.oe = 1'b0; #1;
    chk("oe0_z", bus32(), 32'hFF);
    bus.oe = 1'b1; bus.cs_input = 1'b0; #1;
    chk("cs0_z", bus32(), 32'hFF);
    bus.cs_input = 1'b1; bus.we = 1'b1; #1;
    chk("we1_z", bus32(), 32'hFF);
    bus.we = 1'b0; #1;
    chk("we0_drv", bus32(), 32'h0C);

    // deselected write ignored, read register holds while deselected
    bus.cs_input = 1'b0;
    bus.we       = 1'b1;
    bus.addr     = 8'h00;
    tb_drv       = 8'h77;
    tb_en        = 1'b1;
    @(posedge clk); #1;
    tb_en  = 1'b0;
    bus.we = 1'b0;
    @(posedge clk); #1;
    bus.cs_input = 1'b1; #1;
    chk("cs0_hold", bus32(), 32'h0C);
    rd(8'h00);

    // address boundaries
    wr(8'hFF, 8'hFF);
    wr(8'h1E, 8'hF0);
    rd(8'hFF);
    rd(8'h1E);
    rd(8'hFF);
    rd(8'h00);

    // reset mid-read: bus floats at once, writes ignored, memory kept
    rd(8'h01);
    rst = 1'b1; #1;
    chk("rst_mid_z", bus32(), 32'hFF);
    bus.we = 1'b1;
    tb_drv = 8'h55;
    tb_en  = 1'b1;
    @(posedge clk); #1;
    tb_en  = 1'b0;
    bus.we = 1'b0;
    rst    = 1'b0; #1;
    last   = 0;
    chk("rst_rel", bus32(), 32'h00);
    rd(8'h01);

    // random memory traffic
    for (int i = 0; i < 80; i++) begin
      ad = $urandom_range(2, 255);
      if (!vld[ad] || $urandom_range(0, 1) == 0)
        wr(ad, $urandom_range(0, 255));
      else
        rd(ad);
    end

    // ALU directed
    alu_chk("add1", 1, 8'h05, 8'h07, 8'h0C, 4'b0000);
    alu_chk("add2", 1, 8'hF0, 8'h20, 8'h10, 4'b0010);
    alu_chk("add3", 1, 8'h7F, 8'h01, 8'h80, 4'b1001);
    alu_chk("sub1", 2, 8'h05, 8'h05, 8'h00, 4'b0110);
    alu_chk("sar1", 9, 8'h84, 8'h00, 8'hC2, 4'b1000);
    alu_chk("zero", 14, 8'h5A, 8'hA5, 8'h00, 4'b0100);
    alu_chk("dec0", 13, 8'h00, 8'h00, 8'hFF, 4'b1000);
    alu_chk("inc7f", 12, 8'h7F, 8'h00, 8'h80, 4'b1001);

    // ALU random against model
    for (int i = 0; i < 200; i++) begin
      m = (i < 32) ? i % 16 : $urandom_range(0, 15);
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      alu_ref(m, a, b, s, f);
      alu_chk($sformatf("alu_m%0d", m), m, a, b, s, f);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
